// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic job sequencer: state encoding and the
// default bus map used to drive the systolic array's RAM window.
package systolic_pkg;

  typedef enum logic [3:0] {
    IDLE,
    LOAD,
    KICK,
    POLL_RD,
    POLL_WT,
    RES_RD,
    RES_WT,
    RES_OUT,
    FIN
  } state_t;

  localparam logic [15:0] LOAD_BASE_DFLT = 16'h0000;
  localparam logic [15:0] CTRL_ADR_DFLT  = 16'h0100;
  localparam logic [15:0] STAT_ADR_DFLT  = 16'h0101;
  localparam logic [15:0] RES_BASE_DFLT  = 16'h0200;
  localparam int unsigned POLL_MAX_DFLT  = 1023;
  localparam logic [15:0] KICK_WORD      = 16'h0001;

  // 16-bit modulo address from a base and an 8-bit word index.
  function automatic logic [15:0] addr_off(input logic [15:0] base,
                                           input logic [7:0]  off);
    return base + {8'h00, off};
  endfunction

endpackage

// File: rtl/systolic_seq.sv
// Job sequencer: streams operands into the systolic RAM, kicks the array,
// polls its status, then streams the results back out.
module systolic_seq
  import systolic_pkg::*;
#(
  parameter logic [15:0] LOAD_BASE = LOAD_BASE_DFLT,
  parameter logic [15:0] CTRL_ADR  = CTRL_ADR_DFLT,
  parameter logic [15:0] STAT_ADR  = STAT_ADR_DFLT,
  parameter logic [15:0] RES_BASE  = RES_BASE_DFLT,
  parameter int unsigned POLL_MAX  = POLL_MAX_DFLT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  load_len,
  input  logic [7:0]  res_len,
  output logic        busy,
  output logic        done,
  output logic        timeout,
  input  logic        in_valid,
  input  logic [15:0] in_data,
  output logic        in_ready,
  output logic        out_valid,
  output logic [15:0] out_data,
  input  logic        out_ready,
  output logic        wen,
  output logic [15:0] ibus_wadr,
  output logic [15:0] ibus_wdata,
  output logic        ren,
  output logic [15:0] ibus_radr,
  input  logic [15:0] ibus_rdata
);

  localparam logic [15:0] POLL_LIM = 16'(POLL_MAX);

  state_t      r_state;
  logic [7:0]  r_load_len;
  logic [7:0]  r_res_len;
  logic [7:0]  r_cnt;
  logic [15:0] r_poll;
  logic        r_timeout;
  logic        r_out_valid;
  logic [15:0] r_out_data;

  logic [15:0] w_poll_next;
  logic        w_in_fire;
  logic        w_out_fire;

  assign w_poll_next = r_poll + 16'd1;
  assign w_in_fire   = (r_state == LOAD) && in_valid;
  assign w_out_fire  = (r_state == RES_OUT) && out_ready;

  // Status flags decode directly from the state register, so they are
  // glitch-free and drop to 0 the moment reset forces IDLE.
  assign busy      = (r_state != IDLE);
  assign done      = (r_state == FIN);
  assign in_ready  = (r_state == LOAD);
  assign timeout   = r_timeout;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;

  // Operand writes must land in the handshake cycle itself, so the bus
  // strobes are a pure decode of state plus in_valid rather than registers.
  always_comb begin
    wen        = 1'b0;
    ibus_wadr  = '0;
    ibus_wdata = '0;
    ren        = 1'b0;
    ibus_radr  = '0;
    case (r_state)
      LOAD: begin
        if (in_valid) begin
          wen        = 1'b1;
          ibus_wadr  = addr_off(LOAD_BASE, r_cnt);
          ibus_wdata = in_data;
        end
      end
      KICK: begin
        wen        = 1'b1;
        ibus_wadr  = CTRL_ADR;
        ibus_wdata = KICK_WORD;
      end
      POLL_RD: begin
        ren       = 1'b1;
        ibus_radr = STAT_ADR;
      end
      RES_RD: begin
        ren       = 1'b1;
        ibus_radr = addr_off(RES_BASE, r_cnt);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_load_len  <= '0;
      r_res_len   <= '0;
      r_cnt       <= '0;
      r_poll      <= '0;
      r_timeout   <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_load_len <= load_len;
            r_res_len  <= res_len;
            r_timeout  <= 1'b0;
            r_cnt      <= '0;
            r_poll     <= '0;
            r_state    <= (load_len != 8'd0) ? LOAD : KICK;
          end
        end
        LOAD: begin
          if (w_in_fire) begin
            r_cnt <= r_cnt + 8'd1;
            if (r_cnt == r_load_len - 8'd1) r_state <= KICK;
          end
        end
        KICK:    r_state <= POLL_RD;
        POLL_RD: r_state <= POLL_WT;
        POLL_WT: begin
          if (ibus_rdata[0]) begin
            r_cnt   <= '0;
            r_state <= (r_res_len != 8'd0) ? RES_RD : FIN;
          end else begin
            r_poll <= w_poll_next;
            if (w_poll_next == POLL_LIM) begin
              r_timeout <= 1'b1;
              r_state   <= FIN;
            end else begin
              r_state <= POLL_RD;
            end
          end
        end
        RES_RD: r_state <= RES_WT;
        RES_WT: begin
          r_out_data  <= ibus_rdata;
          r_out_valid <= 1'b1;
          r_state     <= RES_OUT;
        end
        RES_OUT: begin
          if (w_out_fire) begin
            r_out_valid <= 1'b0;
            r_cnt       <= r_cnt + 8'd1;
            r_state     <= (r_cnt == r_res_len - 8'd1) ? FIN : RES_RD;
          end
        end
        FIN:     r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_systolic_seq.sv
// Self-checking bench for systolic_seq: a behavioural RAM/status slave plus a
// transaction-level model of the bus traffic and result stream of each job.
module tb_systolic_seq;

  localparam logic [15:0] LB = 16'h0000;
  localparam logic [15:0] CA = 16'h0100;
  localparam logic [15:0] SA = 16'h0101;
  localparam logic [15:0] RB = 16'h0200;
  localparam int unsigned PM = 1023;
  localparam int unsigned BUDGET = 6000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  load_len = '0;
  logic [7:0]  res_len = '0;
  logic        busy, done, timeout;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = '0;
  logic        in_ready;
  logic        out_valid;
  logic [15:0] out_data;
  logic        out_ready = 1'b0;
  logic        wen, ren;
  logic [15:0] ibus_wadr, ibus_wdata, ibus_radr;
  logic [15:0] ibus_rdata = '0;

  always #5 clk = ~clk;

  systolic_seq #(
    .LOAD_BASE(LB),
    .CTRL_ADR (CA),
    .STAT_ADR (SA),
    .RES_BASE (RB),
    .POLL_MAX (PM)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .load_len  (load_len),
    .res_len   (res_len),
    .busy      (busy),
    .done      (done),
    .timeout   (timeout),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .wen       (wen),
    .ibus_wadr (ibus_wadr),
    .ibus_wdata(ibus_wdata),
    .ren       (ren),
    .ibus_radr (ibus_radr),
    .ibus_rdata(ibus_rdata)
  );

  // Slave: status reports done on the stat_after-th poll of the current job.
  int unsigned stat_polls = 0;
  int unsigned stat_base  = 0;
  int unsigned stat_after = 1;
  logic [15:0] res_mem [256];
  logic [15:0] s_off;

  always @(posedge clk) begin
    s_off = ibus_radr - RB;
    if (ren) begin
      if (ibus_radr == SA) begin
        stat_polls <= stat_polls + 1;
        ibus_rdata <= (stat_polls - stat_base + 32'd1 >= stat_after) ? 16'h0001 : 16'hFFFE;
      end else if (s_off < 16'd256) begin
        ibus_rdata <= res_mem[s_off[7:0]];
      end else begin
        ibus_rdata <= 16'hDEAD;
      end
    end else begin
      ibus_rdata <= 16'($urandom);
    end
  end

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    int unsigned load_len;
    int unsigned res_len;
    int unsigned done_after;
    int unsigned gap_pct;
    int unsigned stall_pct;
    bit          hold_first;
    bit          spam_start;
    bit          seq_ops;
    int unsigned exp_polls;
    bit          exp_to;
  } vec_t;

  logic [31:0] obs_w [$];
  logic [15:0] obs_r [$];
  logic [15:0] obs_o [$];

  task automatic run_job(input vec_t v);
    logic [15:0] ops   [$];
    logic [31:0] exp_w [$];
    logic [15:0] exp_r [$];
    logic [15:0] exp_o [$];
    int unsigned polls, op_idx, cyc, post, done_cnt, stall_left, stat_seen;
    int unsigned proto_err, stab_err;
    bit          to, fin, hold_started, prev_hold;
    logic [15:0] prev_data;

    for (int i = 0; i < 256; i++) res_mem[i] = 16'($urandom);
    for (int unsigned i = 0; i < v.load_len; i++)
      ops.push_back(v.seq_ops ? 16'(i + 1) : 16'($urandom));

    to    = (v.done_after > PM);
    polls = to ? PM : v.done_after;
    for (int unsigned i = 0; i < v.load_len; i++) exp_w.push_back({LB + 16'(i), ops[i]});
    exp_w.push_back({CA, 16'h0001});
    for (int unsigned i = 0; i < polls; i++) exp_r.push_back(SA);
    if (!to) begin
      for (int unsigned i = 0; i < v.res_len; i++) begin
        exp_r.push_back(RB + 16'(i));
        exp_o.push_back(res_mem[i]);
      end
    end

    obs_w.delete(); obs_r.delete(); obs_o.delete();
    stat_base  = stat_polls;
    stat_after = v.done_after;
    load_len   = 8'(v.load_len);
    res_len    = 8'(v.res_len);
    op_idx = 0; cyc = 0; post = 0; done_cnt = 0; stall_left = 0;
    proto_err = 0; stab_err = 0; fin = 0; hold_started = 0; prev_hold = 0;
    prev_data = '0;

    while (!fin && cyc < BUDGET) begin
      @(negedge clk);
      if (cyc == 0) start = 1'b1;
      else start = v.spam_start && busy && !done && ($urandom_range(0, 2) == 0);
      if (op_idx < v.load_len && $urandom_range(0, 99) >= v.gap_pct) begin
        in_valid = 1'b1;
        in_data  = ops[op_idx];
      end else begin
        in_valid = 1'b0;
        in_data  = 16'($urandom);
      end
      if (v.hold_first && out_valid && !hold_started) begin
        hold_started = 1;
        stall_left   = 5;
      end
      if (stall_left > 0) begin
        out_ready = 1'b0;
        stall_left--;
      end else begin
        out_ready = ($urandom_range(0, 99) >= v.stall_pct);
      end
      #1;
      if (wen && ren) proto_err++;
      if (in_ready && !busy) proto_err++;
      if (wen) obs_w.push_back({ibus_wadr, ibus_wdata});
      if (ren) obs_r.push_back(ibus_radr);
      if (in_valid && in_ready) op_idx++;
      if (prev_hold && (!out_valid || out_data !== prev_data || ren)) stab_err++;
      prev_hold = out_valid && !out_ready;
      prev_data = out_data;
      if (out_valid && out_ready) obs_o.push_back(out_data);
      if (cyc == 1) begin
        chk("busy_after_start", 64'(busy), 64'd1);
        chk("timeout_cleared", 64'(timeout), 64'd0);
      end
      if (done) begin
        done_cnt++;
        chk("timeout_at_done", 64'(timeout), 64'(v.exp_to));
      end
      if (done_cnt > 0) begin
        post++;
        if (post > 4) fin = 1;
      end
      cyc++;
    end
    start = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    if (!fin) begin
      fails++;
      tests++;
      $display("FAIL job_budget: got no completion in %0d cycles, required done pulse", BUDGET);
    end

    stat_seen = 0;
    foreach (obs_r[i]) if (obs_r[i] == SA) stat_seen++;
    chk("stat_polls_tbl", 64'(stat_seen), 64'(v.exp_polls));
    chk("timeout_sticky", 64'(timeout), 64'(v.exp_to));
    chk("done_pulses", 64'(done_cnt), 64'd1);
    chk("protocol", 64'(proto_err), 64'd0);
    chk("out_stable", 64'(stab_err), 64'd0);
    chk("write_count", 64'(obs_w.size()), 64'(exp_w.size()));
    for (int i = 0; i < obs_w.size() && i < exp_w.size(); i++)
      chk($sformatf("write[%0d]", i), 64'(obs_w[i]), 64'(exp_w[i]));
    chk("read_count", 64'(obs_r.size()), 64'(exp_r.size()));
    for (int i = 0; i < obs_r.size() && i < exp_r.size(); i++)
      if (obs_r[i] !== exp_r[i] || i == 0)
        chk($sformatf("read[%0d]", i), 64'(obs_r[i]), 64'(exp_r[i]));
    chk("out_count", 64'(obs_o.size()), 64'(exp_o.size()));
    for (int i = 0; i < obs_o.size() && i < exp_o.size(); i++)
      chk($sformatf("out[%0d]", i), 64'(obs_o[i]), 64'(exp_o[i]));
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_flags"}, 64'({busy, done, timeout, in_ready, out_valid, wen, ren, out_data}), 64'd0);
    chk({nm, "_bus"}, 64'({ibus_wadr, ibus_wdata, ibus_radr}), 64'd0);
  endtask

  vec_t vecs [10];
  vec_t rv;

  initial begin
    //           load res done   gap stall hold spam seq  polls to
    vecs[0] = '{   4,  2,    3,   0,   0,   0,   0,   1,    3, 0};
    vecs[1] = '{   0,  0,    1,   0,   0,   0,   0,   0,    1, 0};
    vecs[2] = '{   3,  2, 5000,   0,   0,   0,   0,   0, 1023, 1};
    vecs[3] = '{   2,  3,    1,   0,   0,   1,   0,   0,    1, 0};
    vecs[4] = '{   6,  2,    4,  50,   0,   0,   1,   0,    4, 0};
    vecs[5] = '{  10,  8,    2,  30,  30,   0,   1,   0,    2, 0};
    vecs[6] = '{ 255,  4,    1,  10,  10,   0,   0,   0,    1, 0};
    vecs[7] = '{   1,255,    1,   0,  20,   0,   0,   0,    1, 0};
    vecs[8] = '{   5,  0, 1023,   0,   0,   0,   0,   0, 1023, 0};
    vecs[9] = '{   0,  3,    7,   0,  40,   1,   1,   0,    7, 0};

    #3;
    chk_all_zero("reset_state");
    @(negedge clk);
    rst_n = 1'b1;

    for (int k = 0; k < 10; k++) run_job(vecs[k]);

    for (int k = 0; k < 6; k++) begin
      rv.load_len   = $urandom_range(0, 12);
      rv.res_len    = $urandom_range(0, 6);
      rv.done_after = $urandom_range(1, 12);
      rv.gap_pct    = $urandom_range(0, 60);
      rv.stall_pct  = $urandom_range(0, 60);
      rv.hold_first = 1'($urandom_range(0, 1));
      rv.spam_start = 1'($urandom_range(0, 1));
      rv.seq_ops    = 1'b0;
      rv.exp_polls  = rv.done_after;
      rv.exp_to     = 1'b0;
      run_job(rv);
    end

    // Reset while a result is parked in RES_OUT, then a clean job afterwards.
    begin
      int unsigned w;
      int unsigned strobes;
      load_len   = 8'd0;
      res_len    = 8'd2;
      stat_base  = stat_polls;
      stat_after = 1;
      out_ready  = 1'b0;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      w = 0;
      while (!out_valid && w < 50) begin
        @(negedge clk);
        w++;
      end
      chk("reach_res_out", 64'(out_valid), 64'd1);
      #2 rst_n = 1'b0;
      #1;
      chk_all_zero("async_reset");
      strobes = 0;
      repeat (3) begin
        @(negedge clk);
        if (wen || ren || busy) strobes++;
      end
      chk("no_strobes_in_reset", 64'(strobes), 64'd0);
      rst_n = 1'b1;
      run_job(vecs[0]);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/systolic_seq.md
SYSTOLIC_SEQ -- requirements
Module: systolic_seq

Interface
REQ-001 SHALL have parameters: LOAD_BASE 16'h0000 (first operand write address); CTRL_ADR 16'h0100 (systolic start register); STAT_ADR 16'h0101 (status register, bit0 = done); RES_BASE 16'h0200 (first result read address); POLL_MAX 1023 (status polls before timeout).
REQ-002 SHALL have ports: clk in 1 (single clock); rst_n in 1 (asynchronous, active-low reset).
REQ-003 SHALL have ports: start in 1 (one-cycle job request); load_len in 8 (operand word count); res_len in 8 (result word count).
REQ-004 SHALL have ports: busy out 1 (job active); done out 1 (one-cycle job-end pulse); timeout out 1 (sticky poll-limit flag).
REQ-005 SHALL have ports: in_valid in 1, in_data in 16, in_ready out 1 (operand stream, valid/ready).
REQ-006 SHALL have ports: out_valid out 1, out_data out 16, out_ready in 1 (result stream, valid/ready).
REQ-007 SHALL have ports: wen out 1, ibus_wadr out 16, ibus_wdata out 16, ren out 1, ibus_radr out 16 (systolic RAM bus masters); ibus_rdata in 16 (read data, valid exactly one cycle after ren).

Function
REQ-008 SHALL implement states IDLE, LOAD, KICK, POLL_RD, POLL_WT, RES_RD, RES_WT, RES_OUT, FIN.
REQ-009 IDLE: on start=1, SHALL latch load_len/res_len, clear timeout, zero word/poll counters, go to LOAD (load_len>0) else KICK; start in any other state SHALL be ignored.
REQ-010 LOAD: in_ready=1; each in_valid&in_ready cycle SHALL drive wen=1, ibus_wadr=LOAD_BASE+count, ibus_wdata=in_data in the same cycle, then increment count; after load_len-th word go to KICK.
REQ-011 KICK: SHALL drive wen=1, ibus_wadr=CTRL_ADR, ibus_wdata=16'h0001 for exactly one cycle, then go to POLL_RD.
REQ-012 POLL_RD: SHALL drive ren=1, ibus_radr=STAT_ADR for one cycle, then POLL_WT.
REQ-013 POLL_WT: if ibus_rdata[0]=1 go to RES_RD (res_len>0) else FIN, resetting word counter; else increment poll counter; when poll counter reaches POLL_MAX set timeout=1 and go to FIN, otherwise return to POLL_RD.
REQ-014 RES_RD: SHALL drive ren=1, ibus_radr=RES_BASE+count for one cycle, then RES_WT; RES_WT SHALL register ibus_rdata into out_data, assert out_valid, go to RES_OUT.
REQ-015 RES_OUT: out_valid/out_data SHALL hold stable until out_ready=1; on handshake increment count, deassert out_valid, go to RES_RD, or FIN after res_len-th word.
REQ-016 FIN: done=1 for exactly one cycle, then IDLE.
REQ-017 busy SHALL be 1 in every state except IDLE; in_ready SHALL be 0 outside LOAD; wen and ren SHALL never both be 1.
REQ-018 Address arithmetic SHALL be 16-bit modulo (wraps past 16'hFFFF); counters SHALL be 8-bit, lengths up to 255.
REQ-019 wen, ren, ibus_wadr, ibus_wdata, ibus_radr SHALL be 0 whenever not actively strobed.

Reset
REQ-020 rst_n=0 SHALL asynchronously force IDLE, counters 0, and busy, done, timeout, in_ready, out_valid, out_data, wen, ren and all address/data outputs to 0.
REQ-021 Reset mid-job SHALL abandon the job with no further bus strobes; the next start begins a fresh job.

Structure
REQ-022 State encoding and default address constants SHALL live in shared package systolic_pkg.
REQ-023 Implementation SHALL be one flat module (no sub-modules), roughly 150-250 lines.

Verification
REQ-024 start, load_len=4, res_len=2, operands 1..4 streamed, status done on 3rd poll -> writes 0x0000-0x0003 = 1..4, write 0x0100=0x0001, 3 reads of 0x0101, reads 0x0200/0x0201 delivered on out stream, one done pulse, timeout=0.
REQ-025 load_len=0, res_len=0, status immediately done -> KICK write, one poll, done pulse; no LOAD or result traffic.
REQ-026 status never done -> exactly 1023 polls, timeout=1, done pulse, no result reads; next start clears timeout.
REQ-027 out_ready held 0 for 5 cycles on first result -> out_valid/out_data stable for all 5, no new ren until handshake.
REQ-028 start pulsed during POLL and in_valid gaps during LOAD -> start ignored; writes occur only on handshake cycles with contiguous addresses.
REQ-029 rst_n low during RES_OUT -> all outputs 0 immediately, state IDLE; subsequent job completes normally.
